fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the instruction word used as a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hold request from hazard detection; freezes PC and IF/ID.
REQ-006 redirect  input  1  taken branch/jump; flushes IF/ID and reloads PC.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  32  instruction memory address, equals current PC.
REQ-010 imem_rdata  input  32  instruction word for imem_addr.
REQ-011 imem_valid  input  1  imem_rdata valid for the imem_addr presented in the same cycle.
REQ-012 if_id_pc  output  32  registered PC of the instruction in IF/ID.
REQ-013 if_id_instr  output  32  registered instruction in IF/ID.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-015 States IDLE, REQ and HOLD, in a registered state machine; IDLE SHALL advance to REQ unconditionally after one cycle.
REQ-016 In REQ, imem_req SHALL be 1; in IDLE and HOLD, imem_req SHALL be 0; imem_addr SHALL always equal the PC register.
REQ-017 REQ with imem_valid=1, stall=0 and redirect=0: IF/ID SHALL load {PC, imem_rdata, 1}, PC SHALL advance by 4, and the state SHALL remain REQ.
REQ-018 REQ with imem_valid=1, stall=1 and redirect=0: imem_rdata SHALL be captured in a one-entry skid buffer, IF/ID and PC SHALL hold, and the state SHALL go to HOLD.
REQ-019 REQ with imem_valid=0 and stall=0: IF/ID SHALL load a bubble (if_id_valid=0, if_id_instr=NOP_INSTR), and PC SHALL hold.
REQ-020 REQ with imem_valid=0 and stall=1: IF/ID and PC SHALL hold.
REQ-021 HOLD with stall=1: all state SHALL hold.
REQ-022 HOLD with stall=0: IF/ID SHALL load {PC, skid, 1}, PC SHALL advance by 4, and the state SHALL go to REQ.
REQ-023 Redirect has priority over stall and imem_valid in every state except IDLE.
- PC <= {redirect_pc[31:2], 2'b00}.
- IF/ID <= bubble.
- Skid buffer is discarded.
- Next state is REQ.
REQ-024 Redirect in IDLE SHALL load PC as in REQ-023, and the state SHALL still go to REQ.
REQ-025 PC increment SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-026 if_id_pc SHALL be 0 whenever IF/ID loads a bubble.
REQ-027 Fetch latency: instruction at PC returned with imem_valid in cycle N SHALL appear on IF/ID outputs in cycle N+1 when not stalled.

Reset
REQ-028 rst=1 SHALL set the following, taking priority over all other inputs:
- PC=RESET_PC
- state=IDLE
- imem_req=0
- if_id_valid=0
- if_id_instr=NOP_INSTR
- if_id_pc=0
- skid buffer cleared
REQ-029 Reset asserted mid-HOLD or mid-REQ SHALL discard buffered and in-flight instructions; the first request after release SHALL be to RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_EN SHALL be the sole compile option.
- Defined: adds outputs stall_cycles[31:0] (counts cycles with stall=1 and rst=0) and flush_count[31:0] (counts cycles with redirect=1 and rst=0).
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by rst.
- Undefined: those ports and counters are absent, and all other behaviour is identical.

Verification
REQ-031 Reset release, imem_valid=1 always returning 32'h0010_0093 -> first imem_req in the 2nd cycle at 0x0; if_id shows PC 0x0, 0x4, 0x8 on consecutive cycles, all valid.
REQ-032 Stall during REQ with imem_valid=1 (PC=0x8, rdata 32'hDEAD_0013) held 3 cycles -> IF/ID frozen, imem_req=0 in HOLD; one cycle after stall drops, IF/ID = {0x8, 32'hDEAD_0013, 1}, and the next request is to 0xC.
REQ-033 redirect=1 with redirect_pc=0x103 while stall=1 in HOLD -> next cycle if_id_valid=0, if_id_instr=32'h0000_0013, imem_addr=0x100, state REQ.
REQ-034 PC=32'hFFFF_FFFC with imem_valid=1 -> next imem_addr=0x0.
REQ-035 imem_valid=0 for 2 cycles, no stall -> two bubbles on IF/ID, and PC unchanged.
REQ-036 With FETCH_PERF_EN: 5 stall cycles and 2 redirects -> stall_cycles=5, flush_count=2; rst -> both 0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, one-entry skid buffer
// Optional FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] skid, skid_n;
    logic [31:0] if_id_pc_n, if_id_instr_n;
    logic        if_id_valid_n;

    // Redirect targets are word-aligned; the low bits are dropped on purpose.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            skid        <= '0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            skid        <= skid_n;
            if_id_pc    <= if_id_pc_n;
            if_id_instr <= if_id_instr_n;
            if_id_valid <= if_id_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        skid_n        = skid;
        if_id_pc_n    = if_id_pc;
        if_id_instr_n = if_id_instr;
        if_id_valid_n = if_id_valid;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (redirect) pc_n = {redirect_pc[31:2], 2'b00};
            end
            REQ, HOLD: begin
                if (redirect) begin
                    state_n       = REQ;
                    pc_n          = {redirect_pc[31:2], 2'b00};
                    skid_n        = '0;
                    if_id_pc_n    = '0;
                    if_id_instr_n = NOP_INSTR;
                    if_id_valid_n = 1'b0;
                end else if (state == HOLD) begin
                    if (!stall) begin
                        state_n       = REQ;
                        pc_n          = pc + 32'd4;
                        if_id_pc_n    = pc;
                        if_id_instr_n = skid;
                        if_id_valid_n = 1'b1;
                    end
                end else if (imem_valid) begin
                    if (stall) begin
                        state_n = HOLD;
                        skid_n  = imem_rdata;
                    end else begin
                        pc_n          = pc + 32'd4;
                        if_id_pc_n    = pc;
                        if_id_instr_n = imem_rdata;
                        if_id_valid_n = 1'b1;
                    end
                end else if (!stall) begin
                    if_id_pc_n    = '0;
                    if_id_instr_n = NOP_INSTR;
                    if_id_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
            if (redirect && flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
